// File: rtl/llsc_link_ctrl.sv
// llsc_link_ctrl: LL/SC link controller placed beside the MEM stage.
//
// Owns the LLbit and the link address. An LL links its address granule and an SC
// succeeds only while that link is still intact. The link is killed by an exception
// flush, an ERET, any SC, or a snooped write to the linked granule. The SC result is
// decided combinationally in the SC's own MEM cycle.
//
// Optional feature: define LLSC_TIMEOUT_EN to bound the life of a link to TIMEOUT
// cycles. When the macro is undefined there is no counter.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   flush_i, eret_i  exception flush / ERET commit, both kill the link
//   stall_i          MEM stalled; LL/SC requests are ignored while high
//   ll_req_i         LL in MEM this cycle
//   sc_req_i         SC in MEM this cycle
//   addr_i           LL/SC effective address
//   snoop_we_i       write by another master
//   snoop_addr_i     address of the snooped write
//   sc_success_o     combinational SC result (1 = perform the store)
//   llbit_o          registered LLbit
//   link_addr_o      registered link address, granule offset bits forced to zero
module llsc_link_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned GRAN_BITS = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              eret_i,
    input  logic              stall_i,
    input  logic              ll_req_i,
    input  logic              sc_req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              snoop_we_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              sc_success_o,
    output logic              llbit_o,
    output logic [ADDR_W-1:0] link_addr_o
);

    localparam int unsigned GranW = ADDR_W - GRAN_BITS;

    typedef enum logic [0:0] {
        StIdle,
        StLinked
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [GranW-1:0] r_link_gran;
    logic [GranW-1:0] w_link_gran_d;

    logic             w_ll_v;
    logic             w_sc_v;
    logic             w_linked;
    logic [GranW-1:0] w_addr_gran;
    logic [GranW-1:0] w_snoop_gran;
    logic             w_snoop_hit;
    logic             w_snoop_hits_ll;
    logic             w_expire;

    assign w_ll_v          = ll_req_i & ~stall_i & ~flush_i;
    assign w_sc_v          = sc_req_i & ~stall_i & ~flush_i;
    assign w_linked        = (r_state == StLinked);
    assign w_addr_gran     = addr_i[ADDR_W-1:GRAN_BITS];
    assign w_snoop_gran    = snoop_addr_i[ADDR_W-1:GRAN_BITS];
    assign w_snoop_hit     = snoop_we_i & (w_snoop_gran == r_link_gran);
    // A snoop to the granule being linked in this very cycle wins over the LL.
    assign w_snoop_hits_ll = snoop_we_i & (w_snoop_gran == w_addr_gran);

    assign sc_success_o = w_sc_v & w_linked & (w_addr_gran == r_link_gran)
                        & ~w_snoop_hit & ~eret_i;
    assign llbit_o      = w_linked;
    assign link_addr_o  = {r_link_gran, {GRAN_BITS{1'b0}}};

`ifdef LLSC_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;

    assign w_expire = w_linked & (r_cnt == CntW'(TIMEOUT - 1));

    // Counts cycles spent linked; restarts from zero on every (re)link.
    always_comb begin
        w_cnt_d = '0;
        if ((w_state_d == StLinked) && !w_ll_v) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_link_gran_d = r_link_gran;
        if (w_ll_v) begin
            w_link_gran_d = w_addr_gran;
        end
        if (flush_i || eret_i) begin
            w_state_d = StIdle;
        end else if (w_ll_v) begin
            w_state_d = w_snoop_hits_ll ? StIdle : StLinked;
        end else if (w_sc_v) begin
            w_state_d = StIdle;
        end else if (w_expire) begin
            w_state_d = StIdle;
        end else if (w_linked && w_snoop_hit) begin
            w_state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_link_gran <= '0;
        end else begin
            r_state     <= w_state_d;
            r_link_gran <= w_link_gran_d;
        end
    end

endmodule
